// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light sequencer: state enum, lamp encodings, durations.
// The WALK state exists only when TRAFFIC_WALK_EN is defined.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG_BASE = 3'd0,
    MG_EXT  = 3'd1,
    M_YEL   = 3'd2,
`ifdef TRAFFIC_WALK_EN
    WALK    = 3'd3,
`endif
    SG_BASE = 3'd4,
    SG_EXT  = 3'd5,
    S_YEL   = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef logic [3:0] dur_t;

  // Duration loaded into the timer when a phase is entered.
  function automatic dur_t phase_duration(state_t s, dur_t d_base, dur_t d_ext,
                                          dur_t d_yel, dur_t d_walk);
    dur_t d;
    case (s)
      MG_BASE, SG_BASE: d = d_base;
      MG_EXT, SG_EXT:   d = d_ext;
      M_YEL, S_YEL:     d = d_yel;
      default:          d = d_walk;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/traffic_fsm_if.sv
// Signal bundle between the sequencer (master) and its sensors, timer and lamps (slave).
interface traffic_fsm_if;

  logic                sensor;
  logic                walk_button;
  logic                expired;
  logic                start_timer;
  traffic_pkg::dur_t   timer_value;
  logic [2:0]          main_light;
  logic [2:0]          side_light;
  logic                walk;

  modport master (
    input  sensor, walk_button, expired,
    output start_timer, timer_value, main_light, side_light, walk
  );

  modport slave (
    output sensor, walk_button, expired,
    input  start_timer, timer_value, main_light, side_light, walk
  );

endinterface

// File: rtl/traffic_light_decode.sv
// Pure state-to-lamp decoder; the sequencer registers its outputs.
// Decodes the WALK state only when TRAFFIC_WALK_EN is defined.
module traffic_light_decode
  import traffic_pkg::*;
(
  input  state_t     state,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  always_comb begin
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    case (state)
      MG_BASE, MG_EXT: begin
        main_light = GRN;
        side_light = RED;
      end
      M_YEL: begin
        main_light = YEL;
        side_light = RED;
      end
      SG_BASE, SG_EXT: begin
        main_light = RED;
        side_light = GRN;
      end
      S_YEL: begin
        main_light = RED;
        side_light = YEL;
      end
`ifdef TRAFFIC_WALK_EN
      WALK: begin
        main_light = RED;
        side_light = RED;
        walk       = 1'b1;
      end
`endif
      default: begin
        main_light = RED;
        side_light = RED;
        walk       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/traffic_fsm.sv
// Main/side traffic-light sequencer: loads the phase timer and advances on its expiry pulse.
// Optional pedestrian phase enabled by defining TRAFFIC_WALK_EN.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int T_WALK = 4
) (
  input logic           clk,
  input logic           sys_reset,
  traffic_fsm_if.master bus
);

  generate
    if (T_BASE < 1 || T_BASE > 15) begin : g_bad_t_base
      $error("traffic_fsm: T_BASE=%0d outside 1..15", T_BASE);
    end
    if (T_EXT < 1 || T_EXT > 15) begin : g_bad_t_ext
      $error("traffic_fsm: T_EXT=%0d outside 1..15", T_EXT);
    end
    if (T_YEL < 1 || T_YEL > 15) begin : g_bad_t_yel
      $error("traffic_fsm: T_YEL=%0d outside 1..15", T_YEL);
    end
    if (T_WALK < 1 || T_WALK > 15) begin : g_bad_t_walk
      $error("traffic_fsm: T_WALK=%0d outside 1..15", T_WALK);
    end
  endgenerate

  localparam dur_t D_BASE = dur_t'(T_BASE);
  localparam dur_t D_EXT  = dur_t'(T_EXT);
  localparam dur_t D_YEL  = dur_t'(T_YEL);
  localparam dur_t D_WALK = dur_t'(T_WALK);

  state_t     state_reg, state_next;
  logic       start_reg, start_next;
  dur_t       value_reg, value_next;
  logic [2:0] main_reg, main_next;
  logic [2:0] side_reg, side_next;
  logic       walk_reg, walk_next;
  logic       pending_reg;
  logic       take;

`ifdef TRAFFIC_WALK_EN
  logic pending_next;
`else
  logic walk_button_unused;
  assign walk_button_unused = bus.walk_button;
  assign pending_reg        = 1'b0;
`endif

  // An expiry coinciding with our own load strobe belongs to the old phase and is dropped.
  always_comb begin
    state_next = state_reg;
    take       = !start_reg && bus.expired;
    if (take) begin
      case (state_reg)
        MG_BASE: state_next = bus.sensor ? MG_EXT : M_YEL;
        MG_EXT:  state_next = M_YEL;
        M_YEL: begin
`ifdef TRAFFIC_WALK_EN
          state_next = pending_reg ? WALK : SG_BASE;
`else
          state_next = SG_BASE;
`endif
        end
`ifdef TRAFFIC_WALK_EN
        WALK:    state_next = SG_BASE;
`endif
        SG_BASE: state_next = bus.sensor ? SG_EXT : S_YEL;
        SG_EXT:  state_next = S_YEL;
        S_YEL:   state_next = MG_BASE;
        default: state_next = MG_BASE;
      endcase
    end
    start_next = take;
    value_next = take ? phase_duration(state_next, D_BASE, D_EXT, D_YEL, D_WALK)
                      : value_reg;
  end

`ifdef TRAFFIC_WALK_EN
  // A press on the same edge that enters WALK keeps the request for the next round.
  always_comb begin
    pending_next = pending_reg;
    if (take && state_next == WALK) begin
      pending_next = 1'b0;
    end
    if (bus.walk_button) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      pending_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
    end
  end
`endif

  traffic_light_decode u_decode (
    .state      (state_next),
    .main_light (main_next),
    .side_light (side_next),
    .walk       (walk_next)
  );

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_reg <= MG_BASE;
      start_reg <= 1'b1;
      value_reg <= D_BASE;
      main_reg  <= GRN;
      side_reg  <= RED;
      walk_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
      value_reg <= value_next;
      main_reg  <= main_next;
      side_reg  <= side_next;
      walk_reg  <= walk_next;
    end
  end

  assign bus.start_timer = start_reg;
  assign bus.timer_value = value_reg;
  assign bus.main_light  = main_reg;
  assign bus.side_light  = side_reg;
  assign bus.walk        = walk_reg;

endmodule

// File: tb/tb_traffic_fsm.sv
// Self-checking bench for traffic_fsm with a behavioural countdown timer (enable tied high).
// Walk-phase sequences are exercised when TRAFFIC_WALK_EN is defined.
module tb_traffic_fsm;

  localparam int TB_BASE = 6;
  localparam int TB_EXT  = 3;
  localparam int TB_YEL  = 2;
  localparam int TB_WALK = 4;

  localparam int PH_MG  = 0;
  localparam int PH_MGX = 1;
  localparam int PH_MY  = 2;
  localparam int PH_WK  = 3;
  localparam int PH_SG  = 4;
  localparam int PH_SGX = 5;
  localparam int PH_SY  = 6;

  logic clk = 1'b0;
  logic sys_reset;
  always #5 clk = ~clk;

  traffic_fsm_if tif ();

  traffic_fsm #(
    .T_BASE (TB_BASE),
    .T_EXT  (TB_EXT),
    .T_YEL  (TB_YEL),
    .T_WALK (TB_WALK)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (tif)
  );

  int vectors     = 0;
  int miscompares = 0;

  int t_cnt    = 0;
  bit t_active = 1'b0;

  function automatic int ph_dur(int ph);
    case (ph)
      PH_MG, PH_SG:   return TB_BASE;
      PH_MGX, PH_SGX: return TB_EXT;
      PH_MY, PH_SY:   return TB_YEL;
      default:        return TB_WALK;
    endcase
  endfunction

  function automatic logic [2:0] ph_main(int ph);
    case (ph)
      PH_MG, PH_MGX: return 3'b001;
      PH_MY:         return 3'b010;
      default:       return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ph_side(int ph);
    case (ph)
      PH_SG, PH_SGX: return 3'b001;
      PH_SY:         return 3'b010;
      default:       return 3'b100;
    endcase
  endfunction

  function automatic int next_phase(int ph, bit sens, bit pend);
    case (ph)
      PH_MG:   return sens ? PH_MGX : PH_MY;
      PH_MGX:  return PH_MY;
      PH_MY:   return pend ? PH_WK : PH_SG;
      PH_WK:   return PH_SG;
      PH_SG:   return sens ? PH_SGX : PH_SY;
      PH_SGX:  return PH_SY;
      default: return PH_MG;
    endcase
  endfunction

  // Timer: loads on the strobe edge, counts N cycles, then raises a registered one-cycle expiry.
  task automatic cycle();
    logic next_exp;
    next_exp = 1'b0;
    if (tif.start_timer) begin
      t_cnt    = int'(tif.timer_value);
      t_active = 1'b1;
    end else if (t_active) begin
      if (t_cnt == 1) begin
        next_exp = 1'b1;
        t_active = 1'b0;
      end
      t_cnt = t_cnt - 1;
    end
    @(posedge clk);
    #1;
    tif.expired = next_exp;
  endtask

  task automatic expect_out(string tag, logic [2:0] em, logic [2:0] es, logic ew,
                            logic est, logic [3:0] ev);
    vectors++;
    if ({tif.main_light, tif.side_light, tif.walk, tif.start_timer, tif.timer_value}
        !== {em, es, ew, est, ev}) begin
      miscompares++;
      $display("FAIL %s @%0t: got main=%b side=%b walk=%b start=%b val=%0d, want main=%b side=%b walk=%b start=%b val=%0d",
               tag, $time, tif.main_light, tif.side_light, tif.walk, tif.start_timer,
               tif.timer_value, em, es, ew, est, ev);
    end
  endtask

  task automatic check_phase(string tag, int ph, bit inj, int btn);
    int len;
    len = ph_dur(ph) + 2;
    for (int i = 0; i < len; i++) begin
      expect_out(tag, ph_main(ph), ph_side(ph), ph == PH_WK, i == 0, 4'(ph_dur(ph)));
      tif.walk_button = (i < btn);
      if (i == 0 && inj) tif.expired = 1'b1;
      cycle();
    end
    tif.walk_button = 1'b0;
    $display("phase %s ph=%0d inj=%0d: %0d cycles checked", tag, ph, inj, len);
  endtask

  task automatic do_reset();
    sys_reset       = 1'b1;
    tif.sensor      = 1'b0;
    tif.walk_button = 1'b0;
    tif.expired     = 1'b0;
    t_active        = 1'b0;
    t_cnt           = 0;
    @(posedge clk);
    #1;
    expect_out("reset_hold", 3'b001, 3'b100, 1'b0, 1'b1, 4'(TB_BASE));
    @(negedge clk);
    sys_reset = 1'b0;
    $display("reset released @%0t", $time);
  endtask

  typedef struct {
    bit sensor;
    int ph;
    bit inj;
  } vec_t;

  vec_t vtab[10];

  initial begin
    int ph;
    int pos;
    bit pend;
    int nxt;

    vtab[0] = '{1'b0, PH_MG,  1'b0};
    vtab[1] = '{1'b0, PH_MY,  1'b0};
    vtab[2] = '{1'b0, PH_SG,  1'b1};
    vtab[3] = '{1'b0, PH_SY,  1'b0};
    vtab[4] = '{1'b1, PH_MG,  1'b0};
    vtab[5] = '{1'b1, PH_MGX, 1'b1};
    vtab[6] = '{1'b1, PH_MY,  1'b0};
    vtab[7] = '{1'b1, PH_SG,  1'b0};
    vtab[8] = '{1'b1, PH_SGX, 1'b0};
    vtab[9] = '{1'b1, PH_SY,  1'b1};

    do_reset();
    for (int k = 0; k < 10; k++) begin
      tif.sensor = vtab[k].sensor;
      check_phase("table", vtab[k].ph, vtab[k].inj, 0);
    end
    tif.sensor = 1'b0;
    check_phase("table_wrap", PH_MG, 1'b0, 0);

    // Asynchronous reset in the middle of SG_EXT.
    do_reset();
    tif.sensor = 1'b1;
    check_phase("pre_rst", PH_MG, 1'b0, 0);
    check_phase("pre_rst", PH_MGX, 1'b0, 0);
    check_phase("pre_rst", PH_MY, 1'b0, 0);
    check_phase("pre_rst", PH_SG, 1'b0, 0);
    expect_out("sgx_entry", 3'b100, 3'b001, 1'b0, 1'b1, 4'(TB_EXT));
    cycle();
    cycle();
    #3;
    sys_reset = 1'b1;
    #1;
    expect_out("async_rst", 3'b001, 3'b100, 1'b0, 1'b1, 4'(TB_BASE));
    do_reset();
    check_phase("post_rst", PH_MG, 1'b0, 0);
    check_phase("post_rst", PH_MY, 1'b0, 0);

`ifdef TRAFFIC_WALK_EN
    do_reset();
    check_phase("walk_pulse", PH_MG, 1'b0, 1);
    check_phase("walk_pulse", PH_MY, 1'b0, 0);
    check_phase("walk_pulse", PH_WK, 1'b0, 0);
    check_phase("walk_pulse", PH_SG, 1'b0, 0);
    check_phase("walk_pulse", PH_SY, 1'b0, 0);
    check_phase("walk_pulse", PH_MG, 1'b0, 0);
    check_phase("walk_pulse", PH_MY, 1'b0, 0);
    check_phase("walk_pulse", PH_SG, 1'b0, 0);

    do_reset();
    check_phase("walk_held", PH_MG, 1'b0, 99);
    check_phase("walk_held", PH_MY, 1'b0, 99);
    check_phase("walk_held", PH_WK, 1'b1, 0);
    check_phase("walk_held", PH_SG, 1'b0, 0);
    check_phase("walk_held", PH_SY, 1'b0, 0);
    check_phase("walk_held", PH_MG, 1'b0, 0);
    check_phase("walk_held", PH_MY, 1'b0, 0);
    check_phase("walk_held", PH_WK, 1'b0, 0);
    check_phase("walk_held", PH_SG, 1'b0, 0);
`else
    do_reset();
    check_phase("walk_ignored", PH_MG, 1'b0, 99);
    check_phase("walk_ignored", PH_MY, 1'b0, 99);
    check_phase("walk_ignored", PH_SG, 1'b0, 99);
`endif

    // Randomized run against a phase/duration reference model.
    do_reset();
    ph   = PH_MG;
    pos  = 0;
    pend = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      expect_out("rand", ph_main(ph), ph_side(ph), ph == PH_WK, pos == 0, 4'(ph_dur(ph)));
      tif.sensor      = 1'($urandom_range(0, 1));
      tif.walk_button = ($urandom_range(0, 19) == 0);
      if (pos == 0 && $urandom_range(0, 1) == 1) tif.expired = 1'b1;
`ifdef TRAFFIC_WALK_EN
      if (tif.walk_button) pend = 1'b1;
`endif
      if (pos == ph_dur(ph) + 1) begin
        nxt = next_phase(ph, tif.sensor, pend);
        if (nxt == PH_WK) pend = tif.walk_button;
        $display("rand transition ph=%0d -> ph=%0d @%0t", ph, nxt, $time);
        ph  = nxt;
        pos = 0;
      end else begin
        pos++;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
# traffic_fsm

Main/side-street traffic-light sequencer that drives the countdown timer and consumes its expiry pulse. Each phase is entered by issuing a one-cycle `start_timer` strobe with that phase's duration on `timer_value`. The phase advances only on `expired`. Light outputs go straight to the lamp drivers; `walk` goes to the pedestrian signal.

## Interface
- `T_BASE`, default 6, main/side base green duration in timer ticks (legal 1..15)
- `T_EXT`, default 3, green extension duration when the sensor is active (legal 1..15)
- `T_YEL`, default 2, yellow duration (legal 1..15)
- `T_WALK`, default 4, pedestrian walk duration (legal 1..15; used only when `TRAFFIC_WALK_EN` is defined)
- `clk` input 1 — system clock; all state updates on the rising edge
- `sys_reset` input 1 — asynchronous, active-high reset
- `sensor` input 1 — side-street vehicle present; level, synchronous to `clk`
- `walk_button` input 1 — pedestrian request; level or pulse, synchronous to `clk`
- `expired` input 1 — one-cycle expiry pulse from the timer
- `start_timer` output 1 — one-cycle load strobe to the timer
- `timer_value` output 4 — duration to load; valid whenever `start_timer`=1
- `main_light` output 3 — one-hot {R,Y,G}
- `side_light` output 3 — one-hot {R,Y,G}
- `walk` output 1 — pedestrian walk lamp

## Operation
- States: MG_BASE, MG_EXT, M_YEL, WALK (macro only), SG_BASE, SG_EXT, S_YEL.
- Lights by state:
  - MG_*: main=G, side=R.
  - M_YEL: main=Y, side=R.
  - SG_*: main=R, side=G.
  - S_YEL: main=R, side=Y.
  - WALK: both R, `walk`=1.
- `walk`=0 in every state except WALK.
- Transitions are taken only at an edge where `expired`=1:
  - MG_BASE → MG_EXT if `sensor`=1 at that edge, else → M_YEL.
  - MG_EXT → M_YEL.
  - M_YEL → WALK if `walk_pending`=1 (macro only), else → SG_BASE.
  - WALK → SG_BASE.
  - SG_BASE → SG_EXT if `sensor`=1, else → S_YEL.
  - SG_EXT → S_YEL.
  - S_YEL → MG_BASE.
- Every transition registers `start_timer`=1 for exactly one cycle together with the destination's duration on `timer_value`: BASE→`T_BASE`, EXT→`T_EXT`, YEL→`T_YEL`, WALK→`T_WALK`.
- `timer_value` holds its last value while `start_timer`=0.
- `expired` is ignored while `start_timer`=1. Any `expired` pulse received in that cycle is dropped.
- `walk_pending` register:
  - Set on any edge with `walk_button`=1.
  - Cleared on the edge that enters WALK.
  - If the set and clear happen on the same edge, set wins; the request is served on the next cycle round.
- Durations are 4-bit unsigned. Parameters outside 1..15 are illegal and must be rejected by an elaboration-time check.

## Timing
- Reset values (asynchronous):
  - state=MG_BASE, `main_light`=G, `side_light`=R, `walk`=0, `walk_pending`=0.
  - `start_timer`=1 and `timer_value`=`T_BASE`, so the timer loads on the first edge after reset release.
- Outputs are all registered; no combinational path from inputs to outputs.
- Lights change in the cycle after the edge that sampled `expired`=1, the same cycle `start_timer` is asserted.
- With the timer enable tied high, each phase lasts duration+2 clock cycles: 1 cycle for the strobe, N cycles of countdown, 1 cycle for the registered expiry.
- Reset asserted mid-phase forces the reset values immediately, independent of `clk`. Any pending walk request is lost.

## Configuration
- `TRAFFIC_WALK_EN` defined: WALK state, `walk_pending` and the `T_WALK` path are present.
- `TRAFFIC_WALK_EN` undefined:
  - No WALK state; M_YEL always → SG_BASE.
  - `walk` is tied 0 and `walk_button` is unused.
  - All other behaviour is identical.

## Structure
- Shared package `traffic_pkg`:
  - State enum.
  - Light encodings RED=3'b100, YEL=3'b010, GRN=3'b001.
  - 4-bit duration typedef.
- One natural sub-module: `traffic_light_decode`, a state→{`main_light`, `side_light`, `walk`} decoder whose outputs are registered in `traffic_fsm`.

## Test plan
All scenarios run with the team's timer instantiated and its enable tied to 1.
- Reset, `sensor`=0, no walk → after release: MG_BASE for 8 cycles, M_YEL 4, SG_BASE 8, S_YEL 4, back to MG_BASE. `start_timer` pulses with values 6, 2, 6, 2, 6.
- `sensor`=1 held → MG_BASE(8) → MG_EXT(5) → M_YEL(4) → SG_BASE(8) → SG_EXT(5) → S_YEL(4). EXT strobes carry `timer_value`=3.
- `TRAFFIC_WALK_EN` defined, 1-cycle `walk_button` pulse during MG_BASE → after M_YEL, WALK for 6 cycles with both lights R and `walk`=1, then SG_BASE. The following cycle has no WALK.
- `walk_button` held across the WALK entry edge → `walk_pending` stays 1, and WALK recurs on the next M_YEL exit.
- `sys_reset` asserted mid SG_EXT → lights immediately main=G, side=R. `start_timer`=1 with `timer_value`=6 until the first edge after release.
- Injected `expired`=1 coincident with `start_timer`=1 → no state change, and the phase duration is unaffected.
